// File: rtl/slot_decode_tracker.sv
// -----------------------------------------------------------------------------
// slot_decode_tracker
//
// Registered binary-to-one-hot slot decoder combined with a slot occupancy
// tracker. It allocates the lowest free slot on request and releases slots on
// command. It sits between the wavefront dispatcher and the per-slot state
// tables.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   dec_en/dec_idx  decode request; dec_onehot, dec_valid and dec_err are
//                   registered one cycle later
//   alloc_req       allocate the lowest free slot; alloc_gnt pulses with
//                   alloc_idx/alloc_onehot (these hold when no slot is free)
//   free_en/idx     release a slot; free_err pulses on an unoccupied or
//                   out-of-range index
//   occupied        occupancy vector, one bit per slot
//   count/full/empty number of occupied slots and its boundary flags
// -----------------------------------------------------------------------------
module slot_decode_tracker #(
    parameter int NUM_SLOTS = 40,
    parameter int IDX_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_en,
    input  logic [IDX_WIDTH-1:0] dec_idx,
    output logic [NUM_SLOTS-1:0] dec_onehot,
    output logic                 dec_valid,
    output logic                 dec_err,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [IDX_WIDTH-1:0] alloc_idx,
    output logic [NUM_SLOTS-1:0] alloc_onehot,
    input  logic                 free_en,
    input  logic [IDX_WIDTH-1:0] free_idx,
    output logic                 free_err,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [IDX_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam int CW = IDX_WIDTH + 1;
    localparam logic [CW-1:0] SLOTS_CNT = CW'(NUM_SLOTS);

    // Registered state
    logic [NUM_SLOTS-1:0] dec_onehot_q,   dec_onehot_d;
    logic                 dec_valid_q,    dec_valid_d;
    logic                 dec_err_q,      dec_err_d;
    logic                 alloc_gnt_q,    alloc_gnt_d;
    logic [IDX_WIDTH-1:0] alloc_idx_q,    alloc_idx_d;
    logic [NUM_SLOTS-1:0] alloc_onehot_q, alloc_onehot_d;
    logic                 free_err_q,     free_err_d;
    logic [NUM_SLOTS-1:0] occupied_q,     occupied_d;
    logic [CW-1:0]        count_q,        count_d;
    logic                 full_q,         full_d;
    logic                 empty_q,        empty_d;

    // Per-slot index matches and lowest-free-slot selection
    logic [NUM_SLOTS-1:0]                dec_hit;
    logic [NUM_SLOTS-1:0]                free_hit;
    logic [NUM_SLOTS-1:0]                avail;
    logic [NUM_SLOTS-1:0]                pick_oh;
    logic [IDX_WIDTH-1:0]                pick_idx;
    logic [IDX_WIDTH-1:0][NUM_SLOTS-1:0] idx_mask;
    logic                                free_ok;

    // An index >= NUM_SLOTS matches no slot, so an all-zero hit vector is the
    // out-of-range indication for both the decode and free paths.
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign dec_hit[g]  = (dec_idx  == IDX_WIDTH'(g));
        assign free_hit[g] = (free_idx == IDX_WIDTH'(g));
        for (genvar b = 0; b < IDX_WIDTH; b++) begin : g_bit
            assign idx_mask[b][g] = (((g >> b) & 1) != 0);
        end
    end

    // x & -x isolates the lowest set bit: the lowest free slot as one-hot.
    // Selection uses the registered occupancy, so a slot being freed this
    // cycle still looks occupied and cannot be granted until next cycle.
    assign avail   = ~occupied_q;
    assign pick_oh = avail & (~avail + NUM_SLOTS'(1));

    // One-hot to binary: index bit b is set if the chosen slot has bit b set.
    for (genvar b = 0; b < IDX_WIDTH; b++) begin : g_enc
        assign pick_idx[b] = |(pick_oh & idx_mask[b]);
    end

    // Decode path; onehot holds its last value while dec_en is low
    always_comb begin
        dec_onehot_d = dec_onehot_q;
        dec_valid_d  = dec_en;
        dec_err_d    = 1'b0;
        if (dec_en) begin
            dec_onehot_d = dec_hit;
            dec_err_d    = ~(|dec_hit);
        end
    end

    // Allocation / free / occupancy bookkeeping
    always_comb begin
        alloc_gnt_d    = alloc_req & (|avail);
        alloc_idx_d    = alloc_idx_q;
        alloc_onehot_d = alloc_onehot_q;
        free_ok        = free_en & (|(free_hit & occupied_q));
        free_err_d     = free_en & ~free_ok;
        occupied_d     = occupied_q;
        count_d        = count_q;

        if (alloc_gnt_d) begin
            alloc_idx_d    = pick_idx;
            alloc_onehot_d = pick_oh;
            occupied_d     = occupied_d | pick_oh;
        end
        if (free_ok) begin
            occupied_d = occupied_d & ~free_hit;
        end

        // A granted slot is never the freed one, so a simultaneous grant and
        // free leave the count unchanged.
        if (alloc_gnt_d && !free_ok) begin
            count_d = count_q + CW'(1);
        end else if (!alloc_gnt_d && free_ok) begin
            count_d = count_q - CW'(1);
        end

        full_d  = (count_d == SLOTS_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_onehot_q   <= '0;
            dec_valid_q    <= 1'b0;
            dec_err_q      <= 1'b0;
            alloc_gnt_q    <= 1'b0;
            alloc_idx_q    <= '0;
            alloc_onehot_q <= '0;
            free_err_q     <= 1'b0;
            occupied_q     <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
        end else begin
            dec_onehot_q   <= dec_onehot_d;
            dec_valid_q    <= dec_valid_d;
            dec_err_q      <= dec_err_d;
            alloc_gnt_q    <= alloc_gnt_d;
            alloc_idx_q    <= alloc_idx_d;
            alloc_onehot_q <= alloc_onehot_d;
            free_err_q     <= free_err_d;
            occupied_q     <= occupied_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
        end
    end

    assign dec_onehot   = dec_onehot_q;
    assign dec_valid    = dec_valid_q;
    assign dec_err      = dec_err_q;
    assign alloc_gnt    = alloc_gnt_q;
    assign alloc_idx    = alloc_idx_q;
    assign alloc_onehot = alloc_onehot_q;
    assign free_err     = free_err_q;
    assign occupied     = occupied_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;

`ifndef SYNTHESIS
    count_matches_popcount: assert property (@(posedge clk) disable iff (!rst_n)
        count_q == CW'($countones(occupied_q)));
`endif

endmodule

// File: tb/tb_slot_decode_tracker.sv
// -----------------------------------------------------------------------------
// tb_slot_decode_tracker
//
// Bench for slot_decode_tracker. One instance uses the default 40-slot
// configuration and runs against a behavioural model. A second instance uses
// 8 slots and runs a table of vectors with expected outputs.
// -----------------------------------------------------------------------------
module tb_slot_decode_tracker;

    localparam int N  = 40;
    localparam int W  = 6;
    localparam int N2 = 8;
    localparam int W2 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration instance
    logic         dec_en, alloc_req, free_en;
    logic [W-1:0] dec_idx, free_idx, alloc_idx;
    logic [N-1:0] dec_onehot, alloc_onehot, occupied;
    logic         dec_valid, dec_err, alloc_gnt, free_err, full, empty;
    logic [W:0]   count;

    // 8-slot instance
    logic          b_dec_en, b_alloc_req, b_free_en;
    logic [W2-1:0] b_dec_idx, b_free_idx, b_alloc_idx;
    logic [N2-1:0] b_dec_onehot, b_alloc_onehot, b_occupied;
    logic          b_dec_valid, b_dec_err, b_alloc_gnt, b_free_err, b_full, b_empty;
    logic [W2:0]   b_count;

    slot_decode_tracker #(.NUM_SLOTS(N), .IDX_WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dec_en(dec_en), .dec_idx(dec_idx), .dec_onehot(dec_onehot),
        .dec_valid(dec_valid), .dec_err(dec_err),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
        .alloc_onehot(alloc_onehot),
        .free_en(free_en), .free_idx(free_idx), .free_err(free_err),
        .occupied(occupied), .count(count), .full(full), .empty(empty)
    );

    slot_decode_tracker #(.NUM_SLOTS(N2), .IDX_WIDTH(W2)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .dec_en(b_dec_en), .dec_idx(b_dec_idx), .dec_onehot(b_dec_onehot),
        .dec_valid(b_dec_valid), .dec_err(b_dec_err),
        .alloc_req(b_alloc_req), .alloc_gnt(b_alloc_gnt), .alloc_idx(b_alloc_idx),
        .alloc_onehot(b_alloc_onehot),
        .free_en(b_free_en), .free_idx(b_free_idx), .free_err(b_free_err),
        .occupied(b_occupied), .count(b_count), .full(b_full), .empty(b_empty)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the 40-slot instance ----------------
    bit           m_occ [N];
    logic [N-1:0] m_dec_oh;
    bit           m_dec_valid, m_dec_err, m_gnt, m_ferr;
    int           m_aidx;
    logic [N-1:0] m_aoh;

    task automatic model_reset();
        foreach (m_occ[i]) m_occ[i] = 1'b0;
        m_dec_oh    = '0;
        m_dec_valid = 1'b0;
        m_dec_err   = 1'b0;
        m_gnt       = 1'b0;
        m_ferr      = 1'b0;
        m_aidx      = 0;
        m_aoh       = '0;
    endtask

    function automatic int m_count();
        int c = 0;
        foreach (m_occ[i]) c += int'(m_occ[i]);
        return c;
    endfunction

    function automatic logic [N-1:0] m_occ_vec();
        logic [N-1:0] v = '0;
        foreach (m_occ[i]) if (m_occ[i]) v = v | (N'(1) << i);
        return v;
    endfunction

    // Applies the current inputs of the 40-slot instance to the model, as the
    // next clock edge will.
    task automatic model_step();
        int pick = -1;
        int fi   = int'(free_idx);
        int di   = int'(dec_idx);
        bit fok  = 1'b0;
        if (dec_en) begin
            m_dec_valid = 1'b1;
            m_dec_err   = (di >= N);
            m_dec_oh    = (di < N) ? (N'(1) << di) : '0;
        end else begin
            m_dec_valid = 1'b0;
            m_dec_err   = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!m_occ[i]) begin
                pick = i;
                break;
            end
        end
        if (free_en && fi < N) fok = m_occ[fi];
        m_ferr = free_en && !fok;
        if (alloc_req && pick >= 0) begin
            m_gnt      = 1'b1;
            m_aidx     = pick;
            m_aoh      = N'(1) << pick;
            m_occ[pick] = 1'b1;
        end else begin
            m_gnt = 1'b0;
        end
        if (fok) m_occ[fi] = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int c = m_count();
        chk({tag, ".dec_onehot"},   64'(dec_onehot),   64'(m_dec_oh));
        chk({tag, ".dec_valid"},    64'(dec_valid),    64'(m_dec_valid));
        chk({tag, ".dec_err"},      64'(dec_err),      64'(m_dec_err));
        chk({tag, ".alloc_gnt"},    64'(alloc_gnt),    64'(m_gnt));
        chk({tag, ".alloc_idx"},    64'(alloc_idx),    64'(m_aidx));
        chk({tag, ".alloc_onehot"}, 64'(alloc_onehot), 64'(m_aoh));
        chk({tag, ".free_err"},     64'(free_err),     64'(m_ferr));
        chk({tag, ".occupied"},     64'(occupied),     64'(m_occ_vec()));
        chk({tag, ".count"},        64'(count),        64'(c));
        chk({tag, ".full"},         64'(full),         64'(c == N));
        chk({tag, ".empty"},        64'(empty),        64'(c == 0));
    endtask

    task automatic drive(input bit de, input int di, input bit ar, input bit fe, input int fi);
        dec_en    = de;
        dec_idx   = W'(di);
        alloc_req = ar;
        free_en   = fe;
        free_idx  = W'(fi);
    endtask

    // Inputs are set 1 time unit after an edge; outputs are sampled at the
    // same offset after the following edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".immediate"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    // ---------------- vector table for the 8-slot instance ----------------
    typedef struct {
        bit          de;
        logic [2:0]  di;
        bit          ar;
        bit          fe;
        logic [2:0]  fi;
        bit          e_gnt;
        logic [2:0]  e_aidx;
        bit          e_ferr;
        logic [3:0]  e_cnt;
        logic [7:0]  e_occ;
        logic [7:0]  e_doh;
    } vec_t;

    vec_t vec [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            de di    ar fe fi     gnt aidx ferr cnt   occ    doh
        vec[0]  = '{1, 3'd7, 1, 0, 3'd0, 1, 3'd0, 0, 4'd1, 8'h01, 8'h80};
        vec[1]  = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd1, 0, 4'd2, 8'h03, 8'h80};
        vec[2]  = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd2, 0, 4'd3, 8'h07, 8'h80};
        vec[3]  = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd3, 0, 4'd4, 8'h0F, 8'h80};
        vec[4]  = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd4, 0, 4'd5, 8'h1F, 8'h80};
        vec[5]  = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd5, 0, 4'd6, 8'h3F, 8'h80};
        vec[6]  = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd6, 0, 4'd7, 8'h7F, 8'h80};
        vec[7]  = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd7, 0, 4'd8, 8'hFF, 8'h80};
        vec[8]  = '{0, 3'd0, 1, 0, 3'd0, 0, 3'd7, 0, 4'd8, 8'hFF, 8'h80};
        vec[9]  = '{0, 3'd0, 0, 1, 3'd3, 0, 3'd7, 0, 4'd7, 8'hF7, 8'h80};
        vec[10] = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd3, 0, 4'd8, 8'hFF, 8'h80};
        vec[11] = '{0, 3'd0, 1, 1, 3'd5, 0, 3'd3, 0, 4'd7, 8'hDF, 8'h80};
        vec[12] = '{0, 3'd0, 0, 1, 3'd5, 0, 3'd3, 1, 4'd7, 8'hDF, 8'h80};
        vec[13] = '{0, 3'd0, 1, 1, 3'd0, 1, 3'd5, 0, 4'd7, 8'hFE, 8'h80};
        vec[14] = '{0, 3'd0, 1, 0, 3'd0, 1, 3'd0, 0, 4'd8, 8'hFF, 8'h80};
        vec[15] = '{1, 3'd2, 0, 0, 3'd0, 0, 3'd0, 0, 4'd8, 8'hFF, 8'h04};

        drive(0, 0, 0, 0, 0);
        b_dec_en = 0; b_dec_idx = '0; b_alloc_req = 0; b_free_en = 0; b_free_idx = '0;
        model_reset();

        // Reset release
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("reset");
        chk("reset8.count", 64'(b_count), 64'(0));
        chk("reset8.empty", 64'(b_empty), 64'(1));
        chk("reset8.full",  64'(b_full),  64'(0));

        // 8-slot table
        for (int k = 0; k < 16; k++) begin
            b_dec_en    = vec[k].de;
            b_dec_idx   = vec[k].di;
            b_alloc_req = vec[k].ar;
            b_free_en   = vec[k].fe;
            b_free_idx  = vec[k].fi;
            cycle();
            chk($sformatf("v%0d.alloc_gnt", k),  64'(b_alloc_gnt),  64'(vec[k].e_gnt));
            chk($sformatf("v%0d.alloc_idx", k),  64'(b_alloc_idx),  64'(vec[k].e_aidx));
            chk($sformatf("v%0d.free_err", k),   64'(b_free_err),   64'(vec[k].e_ferr));
            chk($sformatf("v%0d.count", k),      64'(b_count),      64'(vec[k].e_cnt));
            chk($sformatf("v%0d.occupied", k),   64'(b_occupied),   64'(vec[k].e_occ));
            chk($sformatf("v%0d.dec_onehot", k), 64'(b_dec_onehot), 64'(vec[k].e_doh));
            chk($sformatf("v%0d.dec_valid", k),  64'(b_dec_valid),  64'(vec[k].de));
            chk($sformatf("v%0d.dec_err", k),    64'(b_dec_err),    64'(0));
            chk($sformatf("v%0d.full", k),       64'(b_full),       64'(vec[k].e_cnt == 4'd8));
            chk($sformatf("v%0d.empty", k),      64'(b_empty),      64'(vec[k].e_cnt == 4'd0));
            if (vec[k].e_gnt)
                chk($sformatf("v%0d.alloc_onehot", k), 64'(b_alloc_onehot), 64'(1) << vec[k].e_aidx);
        end
        b_dec_en = 0; b_alloc_req = 0; b_free_en = 0;

        // Decode sweep over the whole index range
        for (int i = 0; i < 64; i++) begin
            drive(1, i, 0, 0, 0);
            cycle();
            check_all($sformatf("dec%0d", i));
        end
        drive(0, 0, 0, 0, 0);
        cycle();
        check_all("dec_hold");

        // Fill to full and one extra request
        for (int i = 0; i < 41; i++) begin
            drive(0, 0, 1, 0, 0);
            cycle();
            check_all($sformatf("fill%0d", i));
            if (i == 39) begin
                chk("fill.count40", 64'(count), 64'(40));
                chk("fill.full",    64'(full),  64'(1));
            end
        end
        chk("fill.extra_gnt", 64'(alloc_gnt), 64'(0));

        // Free one slot from full, then reallocate it
        drive(0, 0, 0, 1, 17);
        cycle();
        check_all("free17");
        chk("free17.count", 64'(count), 64'(39));
        drive(0, 0, 1, 0, 0);
        cycle();
        check_all("realloc17");
        chk("realloc17.idx",    64'(alloc_idx),    64'(17));
        chk("realloc17.onehot", 64'(alloc_onehot), 64'(1) << 17);

        // Asynchronous reset with five slots occupied and a request pending
        async_reset("rst_full");
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0);
            cycle();
            check_all($sformatf("five%0d", i));
        end
        async_reset("rst_five");
        chk("rst_five.count", 64'(count), 64'(0));

        // Simultaneous alloc and free
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0);
            cycle();
            check_all($sformatf("three%0d", i));
        end
        drive(0, 0, 1, 1, 1);
        cycle();
        check_all("simul");
        chk("simul.idx",      64'(alloc_idx), 64'(3));
        chk("simul.occupied", 64'(occupied),  64'(13));
        chk("simul.count",    64'(count),     64'(3));
        drive(0, 0, 1, 0, 0);
        cycle();
        check_all("after_simul");
        chk("after_simul.idx", 64'(alloc_idx), 64'(1));

        // Error frees: unoccupied slot and out-of-range index
        drive(0, 0, 0, 1, 5);
        cycle();
        check_all("ferr5");
        chk("ferr5.free_err", 64'(free_err), 64'(1));
        chk("ferr5.count",    64'(count),    64'(4));
        drive(0, 0, 0, 0, 0);
        cycle();
        check_all("ferr_clear");
        drive(0, 0, 0, 1, 45);
        cycle();
        check_all("ferr45");
        chk("ferr45.free_err", 64'(free_err), 64'(1));
        chk("ferr45.occupied", 64'(occupied), 64'(15));

        // Randomised traffic with alternating allocation pressure
        for (int i = 0; i < 3000; i++) begin
            int ap = ((i / 500) % 2 == 0) ? 7 : 2;
            int fi = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63))
                                                 : int'($urandom_range(0, N - 1));
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  ($urandom_range(0, 9) < ap), ($urandom_range(0, 9) < 5), fi);
            cycle();
            check_all($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/slot_decode_tracker.md
# slot_decode_tracker

Parametrised successor to the fixed 6-to-40 one-hot decoder. It decodes a binary slot index into a registered NUM_SLOTS-wide one-hot vector, and keeps a per-slot occupancy vector. It also allocates the lowest free slot on request and releases slots on command. It sits between the wavefront dispatcher and the per-slot state tables of the compute unit (default 40 wavefront slots), replacing the combinational decode plus ad-hoc valid bookkeeping.

## Interface
Parameters:
- NUM_SLOTS, default 40, number of slots; legal range 2..2^IDX_WIDTH.
- IDX_WIDTH, default 6, width of every slot index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dec_en  input  1  request a registered decode of dec_idx.
- dec_idx  input  IDX_WIDTH  index to decode.
- dec_onehot  output  NUM_SLOTS  registered one-hot of dec_idx.
- dec_valid  output  1  dec_onehot is valid this cycle.
- dec_err  output  1  decoded index was ≥ NUM_SLOTS.
- alloc_req  input  1  request allocation of one free slot.
- alloc_gnt  output  1  allocation succeeded (registered pulse).
- alloc_idx  output  IDX_WIDTH  granted slot index.
- alloc_onehot  output  NUM_SLOTS  granted slot, one-hot.
- free_en  input  1  release slot free_idx.
- free_idx  input  IDX_WIDTH  slot to release.
- free_err  output  1  free of an unoccupied or out-of-range slot (registered pulse).
- occupied  output  NUM_SLOTS  occupancy vector.
- count  output  IDX_WIDTH+1  number of occupied slots.
- full, empty  output  1  count == NUM_SLOTS / count == 0.

## Operation
- **Decode path:**
  - When dec_en is high at an edge, the block registers dec_onehot[i] = (dec_idx == i) for i < NUM_SLOTS, and sets dec_valid=1.
  - If dec_idx ≥ NUM_SLOTS, dec_onehot is all-zero and dec_err=1.
  - When dec_en is low, dec_valid=0 and dec_err=0, and dec_onehot holds its last value.
- **Allocation:**
  - On alloc_req, the block selects the lowest-index slot i with occupied[i]==0, using the occupancy state registered at the start of the cycle.
  - If a slot exists: set occupied[i], pulse alloc_gnt=1 with alloc_idx=i and alloc_onehot bit i.
  - If full: alloc_gnt=0, and alloc_idx/alloc_onehot hold their previous values.
- **Free:**
  - On free_en with free_idx < NUM_SLOTS and occupied[free_idx]==1, clear that bit.
  - Otherwise there is no state change and free_err pulses.
- **Simultaneous alloc and free in one cycle:**
  - Both take effect.
  - The slot being freed is not eligible for this cycle's allocation; it becomes eligible from the next cycle.
  - count changes by +1−1 = 0 when both succeed.
- Decode and alloc/free are independent; the decode path never reads or changes occupancy.
- count, full and empty always reflect the registered occupied vector; they are maintained incrementally or by popcount, but must be equal to popcount(occupied).
- Reset values: occupied, count, dec_onehot, alloc_onehot and alloc_idx are 0; dec_valid, dec_err, alloc_gnt and free_err are 0; empty=1, full=0.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Decode, allocation and free all have 1-cycle latency: the edge that samples the request updates the outputs.
- Back-to-back alloc_req every cycle grants consecutive free slots, one per cycle, until full.
- A free in cycle N makes its slot allocatable by a request sampled in cycle N+1.
- Asserting rst_n low mid-operation immediately clears all state, regardless of clk. Requests in flight are dropped with no grant.
- On the first edge after rst_n deasserts, requests are processed normally.

## Test plan
- **Reset:** hold rst_n=0 then release → occupied=0, count=0, empty=1, full=0, all pulses 0. Then assert rst_n=0 asynchronously mid-run with 5 slots occupied → count=0 at once, before the next edge.
- **Decode sweep (defaults):** dec_en=1 with dec_idx=0..63 → for idx<40, dec_onehot == 1<<idx one cycle later with dec_valid=1; for idx 40..63, dec_onehot=0 with dec_err=1.
- **Fill to full:** alloc_req=1 for 41 cycles from empty → grants 0..39 in order, full=1 and count=40 after the 40th grant, 41st cycle alloc_gnt=0.
- **Free then reallocate:**
  - With all slots occupied, free_idx=17 → count=39.
  - Next alloc_req → alloc_idx=17, alloc_onehot bit 17.
- **Simultaneous alloc and free:**
  - Occupied = {0,1,2}; in one cycle free_idx=1 and alloc_req → grant idx 3, occupied={0,2,3}, count=3.
  - Next-cycle alloc → idx 1.
- **Error frees:** free_idx=5 when slot 5 is unoccupied, and free_idx=45 → free_err=1 for one cycle each, with occupied and count unchanged. Repeat with NUM_SLOTS=8, IDX_WIDTH=3 to check parametrisation.
